multicycle_cu: RTL
==================

MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 Parameter XLEN, default 32, width of the retired-instruction counter.
REQ-002 Parameter RESET_STATE, default 3'd0 (FETCH), state entered on reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 instr  in  32  instruction word from instruction memory.
REQ-006 imem_valid  in  1  instr valid this cycle.
REQ-007 dmem_ready  in  1  data memory completes the access this cycle.
REQ-008 branch_taken  in  1  branch comparator result for the latched func3.
REQ-009 imem_req  out  1  fetch request.
REQ-010 ir_we, pc_we, rf_we, dm_req, dm_we  out  1 each  write/request strobes.
REQ-011 alu_src_a  out  1  0=reg1, 1=pc; alu_src_b  out  1  0=reg2, 1=imm.
REQ-012 pc_sel  out  1  0=pc+4, 1=ALU result; wb_sel  out  2  00=dm, 01=alu, 10=pc+4.
REQ-013 rs1, rs2, rd  out  5 each; func3  out  3; subsra  out  1 (instr[30] for R-type, else 0).
REQ-014 state  out  3  current FSM state; illegal  out  1  sticky trap flag; instret  out  XLEN  retired count.

Function
REQ-015 The block SHALL be a Moore FSM: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to FETCH.
REQ-016 FETCH: imem_req=1; while imem_valid=0 stay; on imem_valid=1 assert ir_we and latch instr, next DECODE.
REQ-017 DECODE: latch rs1, rs2, rd, func3, subsra from the latched instr; opcodes 0110011, 0010011, 0000011, 0100011, 1100011 go to EXEC; any other opcode goes to TRAP.
REQ-018 For opcodes other than R-type, rs2 SHALL be 0 for I-type and load; rd SHALL be 0 for store and branch.
REQ-019 EXEC, R/I-ALU: alu_src_a=0, alu_src_b=(I-type), next WB. Load/store: alu_src_b=1, next MEM.
REQ-020 EXEC, branch: pc_we=1, pc_sel=branch_taken, alu_src_a=1, alu_src_b=1, instret+1, next FETCH.
REQ-021 MEM: dm_req=1, dm_we=1 for store only; hold both until dmem_ready=1. A load then goes to WB. A store then asserts pc_we=1, pc_sel=0, increments instret, and goes to FETCH.
REQ-022 WB: rf_we=1 unless rd=0, wb_sel 00 (load) or 01 (ALU), pc_we=1, pc_sel=0, instret+1, next FETCH.
REQ-023 Strobes not listed for a state SHALL be 0. Mux selects are don't-care when they do not qualify a strobe and SHALL be driven 0.
REQ-024 Minimum latency with imem_valid/dmem_ready tied high: branch 3, ALU/store 4, load 5 cycles.
REQ-025 instret SHALL be XLEN-bit modulo 2^XLEN: all-ones+1 wraps to 0 with no flag.
REQ-026 TRAP: illegal=1, all strobes 0, remain until reset.
REQ-027 dmem_ready or imem_valid asserted in a state that does not wait for it SHALL be ignored.

Reset
REQ-028 While reset=1, all strobes and imem_req SHALL be forced 0 combinationally, regardless of state, including mid-MEM or mid-FETCH.
REQ-029 On the first edge with reset=1: state=RESET_STATE; instret, illegal, latched instr and fields = 0.

Configuration
REQ-030 Macro CU_JUMP_EN: when defined, JAL (1101111) and JALR (1100111) are legal. EXEC goes to WB with wb_sel=10, rf_we=1 (rd≠0), pc_we=1, pc_sel=1, alu_src_b=1, and alu_src_a=1 for JAL, 0 for JALR. When undefined, both opcodes go to TRAP.

Verification
REQ-031 add x3,x1,x2 (0x002081B3), imem_valid=1 -> states 0,1,2,4. In WB: rf_we=1, rd=3, wb_sel=01, pc_we=1. instret 0->1.
REQ-032 lw x5,8(x1) (0x0080A283), dmem_ready low 3 cycles -> dm_req high 4 cycles, dm_we=0, then WB rd=5, wb_sel=00. Total 8 cycles.
REQ-033 beq x1,x2,+8 (0x00208463), branch_taken=1 -> EXEC pc_we=1, pc_sel=1, rf_we never 1, back to FETCH after 3 cycles.
REQ-034 sw x2,4(x1) (0x0020A223) -> MEM dm_we=1, func3=010, rs2=2, rf_we never 1. Reset asserted during MEM -> dm_req=0 same cycle, state=0 next.
REQ-035 instr 0x00000000 -> TRAP in cycle 3, illegal=1 for 10 further cycles, instret unchanged. Reset -> state=0, illegal=0.
REQ-036 jal x1,+8 (0x008000EF): with CU_JUMP_EN -> WB rf_we=1, rd=1, wb_sel=10, pc_sel=1. Without CU_JUMP_EN -> TRAP. With XLEN=4, 16 ALU retires -> instret returns to 0.

Source files
------------

// File: rtl/multicycle_cu_if.sv
// Bus between the multicycle control unit and its datapath/memory side.
// master: the control unit (consumes instr/handshakes, drives strobes, selects and status).
// slave:  the datapath/memory side.
interface multicycle_cu_if #(
  parameter int XLEN = 32
) ();
  logic [31:0]     instr;
  logic            imem_valid;
  logic            dmem_ready;
  logic            branch_taken;
  logic            imem_req;
  logic            ir_we;
  logic            pc_we;
  logic            rf_we;
  logic            dm_req;
  logic            dm_we;
  logic            alu_src_a;
  logic            alu_src_b;
  logic            pc_sel;
  logic [1:0]      wb_sel;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [2:0]      func3;
  logic            subsra;
  logic [2:0]      state;
  logic            illegal;
  logic [XLEN-1:0] instret;

  modport master (
    input  instr, imem_valid, dmem_ready, branch_taken,
    output imem_req, ir_we, pc_we, rf_we, dm_req, dm_we,
    output alu_src_a, alu_src_b, pc_sel, wb_sel,
    output rs1, rs2, rd, func3, subsra, state, illegal, instret
  );

  modport slave (
    output instr, imem_valid, dmem_ready, branch_taken,
    input  imem_req, ir_we, pc_we, rf_we, dm_req, dm_we,
    input  alu_src_a, alu_src_b, pc_sel, wb_sel,
    input  rs1, rs2, rd, func3, subsra, state, illegal, instret
  );
endinterface

// File: rtl/multicycle_cu.sv
// multicycle_cu: Moore-style control FSM for a multicycle RV32 core
// (FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, sticky TRAP).
// Optional feature: define CU_JUMP_EN to accept JAL/JALR; otherwise both trap.
module multicycle_cu #(
  parameter int         XLEN        = 32,
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input logic            clk,
  input logic            reset,
  multicycle_cu_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef CU_JUMP_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

  // Opcodes the unit knows how to sequence; everything else traps.
  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: op_legal = 1'b1;
`ifdef CU_JUMP_EN
      OP_JAL, OP_JALR:                          op_legal = 1'b1;
`endif
      default:                                  op_legal = 1'b0;
    endcase
  endfunction

  state_t          state_r;
  // Only the instruction bits the control unit decodes are kept:
  // {instr[30], instr[24:0]}.
  logic [25:0]     ir_r;
  logic [4:0]      rs1_r, rs2_r, rd_r;
  logic [2:0]      func3_r;
  logic            subsra_r;
  logic            illegal_r;
  logic [XLEN-1:0] instret_r;

  logic [6:0]      op_s;
  logic            is_jump_s;
  logic            imem_req_s, ir_we_s, pc_we_s, rf_we_s, dm_req_s, dm_we_s;
  logic            alu_src_a_s, alu_src_b_s, pc_sel_s;
  logic [1:0]      wb_sel_s;

  assign op_s = ir_r[6:0];
`ifdef CU_JUMP_EN
  assign is_jump_s = (op_s == OP_JAL) || (op_s == OP_JALR);
`else
  assign is_jump_s = 1'b0;
`endif

  // State sequencing, instruction/field latching, retire counter and trap flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= state_t'(RESET_STATE);
      ir_r      <= 26'd0;
      rs1_r     <= 5'd0;
      rs2_r     <= 5'd0;
      rd_r      <= 5'd0;
      func3_r   <= 3'd0;
      subsra_r  <= 1'b0;
      illegal_r <= 1'b0;
      instret_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        S_FETCH: begin
          if (bus.imem_valid) begin
            ir_r    <= {bus.instr[30], bus.instr[24:0]};
            state_r <= S_DECODE;
          end
        end
        S_DECODE: begin
          rs1_r    <= ir_r[19:15];
          rs2_r    <= ((op_s == OP_R) || (op_s == OP_STORE) || (op_s == OP_BRANCH))
                      ? ir_r[24:20] : 5'd0;
          rd_r     <= ((op_s == OP_STORE) || (op_s == OP_BRANCH)) ? 5'd0 : ir_r[11:7];
          func3_r  <= ir_r[14:12];
          subsra_r <= (op_s == OP_R) ? ir_r[25] : 1'b0;
          if (op_legal(op_s)) begin
            state_r <= S_EXEC;
          end else begin
            state_r   <= S_TRAP;
            illegal_r <= 1'b1;
          end
        end
        S_EXEC: begin
          case (op_s)
            OP_R, OP_I: state_r <= S_WB;
`ifdef CU_JUMP_EN
            OP_JAL, OP_JALR: state_r <= S_WB;
`endif
            OP_LOAD, OP_STORE: state_r <= S_MEM;
            OP_BRANCH: begin
              instret_r <= instret_r + {{(XLEN-1){1'b0}}, 1'b1};
              state_r   <= S_FETCH;
            end
            default: begin
              illegal_r <= 1'b1;
              state_r   <= S_TRAP;
            end
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            if (op_s == OP_STORE) begin
              instret_r <= instret_r + {{(XLEN-1){1'b0}}, 1'b1};
              state_r   <= S_FETCH;
            end else begin
              state_r   <= S_WB;
            end
          end
        end
        S_WB: begin
          instret_r <= instret_r + {{(XLEN-1){1'b0}}, 1'b1};
          state_r   <= S_FETCH;
        end
        S_TRAP:  state_r <= S_TRAP;
        default: state_r <= S_FETCH;
      endcase
    end
  end

  // Per-state strobes and mux selects; reset forces everything low immediately.
  always_comb begin
    imem_req_s  = 1'b0;
    ir_we_s     = 1'b0;
    pc_we_s     = 1'b0;
    rf_we_s     = 1'b0;
    dm_req_s    = 1'b0;
    dm_we_s     = 1'b0;
    alu_src_a_s = 1'b0;
    alu_src_b_s = 1'b0;
    pc_sel_s    = 1'b0;
    wb_sel_s    = 2'b00;
    if (reset) begin
      imem_req_s = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          imem_req_s = 1'b1;
          ir_we_s    = bus.imem_valid;
        end
        S_EXEC: begin
          case (op_s)
            OP_R:              alu_src_b_s = 1'b0;
            OP_I:              alu_src_b_s = 1'b1;
            OP_LOAD, OP_STORE: alu_src_b_s = 1'b1;
            OP_BRANCH: begin
              pc_we_s     = 1'b1;
              pc_sel_s    = bus.branch_taken;
              alu_src_a_s = 1'b1;
              alu_src_b_s = 1'b1;
            end
`ifdef CU_JUMP_EN
            OP_JAL: begin
              alu_src_a_s = 1'b1;
              alu_src_b_s = 1'b1;
            end
            OP_JALR:           alu_src_b_s = 1'b1;
`endif
            default:           alu_src_b_s = 1'b0;
          endcase
        end
        S_MEM: begin
          dm_req_s = 1'b1;
          dm_we_s  = (op_s == OP_STORE);
          pc_we_s  = bus.dmem_ready && (op_s == OP_STORE);
        end
        S_WB: begin
          pc_we_s  = 1'b1;
          pc_sel_s = is_jump_s;
          rf_we_s  = (rd_r != 5'd0);
          if (rd_r == 5'd0) begin
            wb_sel_s = 2'b00;
          end else if (is_jump_s) begin
            wb_sel_s = 2'b10;
          end else if (op_s == OP_LOAD) begin
            wb_sel_s = 2'b00;
          end else begin
            wb_sel_s = 2'b01;
          end
        end
        default: imem_req_s = 1'b0;
      endcase
    end
  end

  assign bus.imem_req  = imem_req_s;
  assign bus.ir_we     = ir_we_s;
  assign bus.pc_we     = pc_we_s;
  assign bus.rf_we     = rf_we_s;
  assign bus.dm_req    = dm_req_s;
  assign bus.dm_we     = dm_we_s;
  assign bus.alu_src_a = alu_src_a_s;
  assign bus.alu_src_b = alu_src_b_s;
  assign bus.pc_sel    = pc_sel_s;
  assign bus.wb_sel    = wb_sel_s;
  assign bus.rs1       = rs1_r;
  assign bus.rs2       = rs2_r;
  assign bus.rd        = rd_r;
  assign bus.func3     = func3_r;
  assign bus.subsra    = subsra_r;
  assign bus.state     = state_r;
  assign bus.illegal   = illegal_r;
  assign bus.instret   = instret_r;

endmodule
